// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of the single-ported SOC RAM.
// Port 0 is the processor and port 1 is an auxiliary master. Accesses are
// serialised through IDLE -> ACCESS -> DONE. The RAM strobes are registered
// copies of the granted port's request and are held for exactly one cycle.
// Optional build macro: MEM_ARB_STATS_EN adds saturating grant and conflict
// counters. When it is undefined the stat outputs are tied to zero.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_rstrb,
    input  logic [3:0]            p0_wmask,
    input  logic [31:0]           p0_wdata,
    output logic [31:0]           p0_rdata,
    output logic                  p0_done,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_rstrb,
    input  logic [3:0]            p1_wmask,
    input  logic [31:0]           p1_wdata,
    output logic [31:0]           p1_rdata,
    output logic                  p1_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rstrb,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [15:0]           stat_p0_grants,
    output logic [15:0]           stat_p1_grants,
    output logic [15:0]           stat_conflicts
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_q;
    logic   enter_access;
    logic   other_req;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_rstrb;
    logic [3:0]            sel_wmask;
    logic [31:0]           sel_wdata;

    // Next-state and grant decision; the finishing port is never re-granted from DONE
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        enter_access = 1'b0;
        other_req    = gnt_q ? p0_req : p1_req;
        case (state_q)
            IDLE: begin
                if (p0_req && p1_req) begin
                    enter_access = 1'b1;
                    gnt_d        = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
                end else if (p0_req) begin
                    enter_access = 1'b1;
                    gnt_d        = 1'b0;
                end else if (p1_req) begin
                    enter_access = 1'b1;
                    gnt_d        = 1'b1;
                end
            end
            ACCESS: begin
                state_d = DONE;
            end
            DONE: begin
                if (other_req) begin
                    enter_access = 1'b1;
                    gnt_d        = ~gnt_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enter_access) begin
            state_d = ACCESS;
        end
    end

    // Request mux selecting the port that is about to be granted
    always_comb begin
        sel_addr  = gnt_d ? p1_addr  : p0_addr;
        sel_rstrb = gnt_d ? p1_rstrb : p0_rstrb;
        sel_wmask = gnt_d ? p1_wmask : p0_wmask;
        sel_wdata = gnt_d ? p1_wdata : p0_wdata;
    end

    // State, grant and last-granted registers; last starts at 1 so port 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (enter_access) begin
                last_q <= gnt_d;
            end
        end
    end

    // RAM request registers: loaded on entry to ACCESS, cleared in every other cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_rstrb <= 1'b0;
            mem_wmask <= 4'b0000;
            mem_wdata <= 32'h0;
        end else if (enter_access) begin
            mem_addr  <= sel_addr;
            mem_rstrb <= sel_rstrb;
            mem_wmask <= sel_wmask;
            mem_wdata <= sel_wdata;
        end else begin
            mem_addr  <= '0;
            mem_rstrb <= 1'b0;
            mem_wmask <= 4'b0000;
            mem_wdata <= 32'h0;
        end
    end

    // Completion pulse and read data steered to the granted port only
    always_comb begin
        p0_done  = (state_q == DONE) && !gnt_q;
        p1_done  = (state_q == DONE) &&  gnt_q;
        p0_rdata = p0_done ? mem_rdata : 32'h0;
        p1_rdata = p1_done ? mem_rdata : 32'h0;
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating statistics; a conflict is an IDLE arbitration where both ports ask at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_p0_grants <= 16'h0;
            stat_p1_grants <= 16'h0;
            stat_conflicts <= 16'h0;
        end else begin
            if (enter_access && !gnt_d && (stat_p0_grants != 16'hFFFF)) begin
                stat_p0_grants <= stat_p0_grants + 16'd1;
            end
            if (enter_access && gnt_d && (stat_p1_grants != 16'hFFFF)) begin
                stat_p1_grants <= stat_p1_grants + 16'd1;
            end
            if ((state_q == IDLE) && p0_req && p1_req && (stat_conflicts != 16'hFFFF)) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end
`else
    assign stat_p0_grants = 16'h0;
    assign stat_p1_grants = 16'h0;
    assign stat_conflicts = 16'h0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized two-master
// run scored against a transaction-level memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr;
    logic        p0_rstrb, p1_rstrb;
    logic [3:0]  p0_wmask, p1_wmask;
    logic [31:0] p0_wdata, p1_wdata;

    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] stat_p0_grants, stat_p1_grants, stat_conflicts;

    logic [31:0] fp_p0_rdata, fp_p1_rdata;
    logic        fp_p0_done, fp_p1_done;
    logic [31:0] fp_mem_addr;
    logic        fp_mem_rstrb;
    logic [3:0]  fp_mem_wmask;
    logic [31:0] fp_mem_wdata;
    logic [31:0] fp_mem_rdata;
    logic [15:0] fp_stat_p0, fp_stat_p1, fp_stat_cf;

    logic [31:0] ram [0:63];
    logic [31:0] refm [0:63];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign fp_mem_rdata = 32'h0;

    mem_arbiter #(.ADDR_WIDTH(32), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wmask(p0_wmask),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_done(p0_done),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wmask(p1_wmask),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_done(p1_done),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_p0_grants(stat_p0_grants), .stat_p1_grants(stat_p1_grants),
        .stat_conflicts(stat_conflicts)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wmask(p0_wmask),
        .p0_wdata(p0_wdata), .p0_rdata(fp_p0_rdata), .p0_done(fp_p0_done),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wmask(p1_wmask),
        .p1_wdata(p1_wdata), .p1_rdata(fp_p1_rdata), .p1_done(fp_p1_done),
        .mem_addr(fp_mem_addr), .mem_rstrb(fp_mem_rstrb), .mem_wmask(fp_mem_wmask),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata),
        .stat_p0_grants(fp_stat_p0), .stat_p1_grants(fp_stat_p1),
        .stat_conflicts(fp_stat_cf)
    );

    // One-cycle-latency RAM: read returns pre-write contents, plus a preload port
    always @(posedge clk) begin
        if (pre_en) ram[pre_idx] <= pre_data;
        if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
        for (int i = 0; i < 4; i++) begin
            if (mem_wmask[i]) ram[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_addr = 0; p0_rstrb = 0; p0_wmask = 0; p0_wdata = 0;
        p1_req = 0; p1_addr = 0; p1_rstrb = 0; p1_wmask = 0; p1_wdata = 0;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pre_en = 1'b1; pre_idx = idx[5:0]; pre_data = d;
        refm[idx] = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        pre_en = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1; p0_rstrb = 1'b1;
        rst = 1'b1;
        #3;
        checks++;
        if ({mem_addr, mem_rstrb, mem_wmask, mem_wdata} !== 69'h0) begin
            failures++;
            $display("[TB] FAIL reset_mem got=%h/%b/%b/%h exp=0", mem_addr, mem_rstrb, mem_wmask, mem_wdata);
        end
        checks++;
        if ({p0_done, p1_done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_done got=%b exp=00", {p0_done, p1_done});
        end
        step(); step();
        checks++;
        if ({stat_p0_grants, stat_p1_grants, stat_conflicts} !== 48'h0) begin
            failures++;
            $display("[TB] FAIL reset_stats got=%h/%h/%h exp=0", stat_p0_grants, stat_p1_grants, stat_conflicts);
        end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_p0_read();
        preload(4, 32'hDEADBEEF);
        p0_req = 1; p0_addr = 32'h10; p0_rstrb = 1; p0_wmask = 0; p0_wdata = 0;
        step();
        checks++;
        if ({mem_rstrb, mem_addr, mem_wmask} !== {1'b1, 32'h10, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL p0rd_access got=%b/%h/%b exp=1/00000010/0000", mem_rstrb, mem_addr, mem_wmask);
        end
        checks++;
        if (p0_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL p0rd_early_done got=%b exp=0", p0_done);
        end
        step();
        checks++;
        if ({p0_done, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL p0rd_done got=%b/%h exp=1/deadbeef", p0_done, p0_rdata);
        end
        checks++;
        if ({mem_rstrb, p1_done} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL p0rd_strobe_p1done got=%b/%b exp=0/0", mem_rstrb, p1_done);
        end
        p0_req = 0;
        step();
        checks++;
        if (p0_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL p0rd_pulse got=%b exp=0", p0_done);
        end
    endtask

    task automatic test_write_read();
        preload(8, 32'hAAAAAAAA);
        p1_req = 1; p1_addr = 32'h20; p1_rstrb = 0; p1_wmask = 4'b0011; p1_wdata = 32'h12345678;
        step();
        checks++;
        if ({mem_rstrb, mem_wmask, mem_wdata, mem_addr} !== {1'b0, 4'b0011, 32'h12345678, 32'h20}) begin
            failures++;
            $display("[TB] FAIL p1wr_access got=%b/%b/%h/%h exp=0/0011/12345678/00000020", mem_rstrb, mem_wmask, mem_wdata, mem_addr);
        end
        step();
        checks++;
        if ({p1_done, p0_done, mem_wmask} !== {1'b1, 1'b0, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL p1wr_done got=%b/%b/%b exp=1/0/0000", p1_done, p0_done, mem_wmask);
        end
        p1_req = 0;
        step();
        p1_req = 1; p1_rstrb = 1; p1_wmask = 0; p1_wdata = 0;
        step(); step();
        checks++;
        if ({p1_done, p1_rdata} !== {1'b1, 32'hAAAA5678}) begin
            failures++;
            $display("[TB] FAIL p1rd_merged got=%b/%h exp=1/aaaa5678", p1_done, p1_rdata);
        end
        p1_req = 0;
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_d;
        do_reset();
        p0_req = 1; p0_addr = 32'h10; p0_rstrb = 1;
        p1_req = 1; p1_addr = 32'h20; p1_rstrb = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_d = {(i % 4) == 2, (i % 4) == 0};
            checks++;
            if ({p0_done, p1_done} !== exp_d) begin
                failures++;
                $display("[TB] FAIL rr_pattern step=%0d got=%b exp=%b", i, {p0_done, p1_done}, exp_d);
            end
            if (exp_d[1] && (p0_rdata !== 32'hDEADBEEF)) begin
                failures++;
                $display("[TB] FAIL rr_p0_rdata got=%h exp=deadbeef", p0_rdata);
            end
            if (exp_d[0] && (p1_rdata !== 32'hAAAA5678)) begin
                failures++;
                $display("[TB] FAIL rr_p1_rdata got=%h exp=aaaa5678", p1_rdata);
            end
        end
        idle_inputs();
        step(); step();
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp_d;
        do_reset();
        p0_req = 1; p0_addr = 32'h10; p0_rstrb = 1;
        step(); step();
        p0_req = 0;
        step();
        p0_req = 1; p1_req = 1; p1_addr = 32'h20; p1_rstrb = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_d = {(i % 4) == 2, (i % 4) == 0};
            checks++;
            if ({fp_p0_done, fp_p1_done} !== exp_d) begin
                failures++;
                $display("[TB] FAIL fp_pattern step=%0d got=%b exp=%b", i, {fp_p0_done, fp_p1_done}, exp_d);
            end
            if (i == 2) begin
                checks++;
                if ({p0_done, p1_done} !== 2'b01) begin
                    failures++;
                    $display("[TB] FAIL rr_tie_after_p0 got=%b exp=01", {p0_done, p1_done});
                end
            end
            p0_req = !fp_p0_done;
        end
        idle_inputs();
        step(); step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        p0_req = 1; p0_addr = 32'h10; p0_rstrb = 1;
        step();
        checks++;
        if (mem_rstrb !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_access got=%b exp=1", mem_rstrb);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_rstrb !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_async_strobe got=%b exp=0", mem_rstrb);
        end
        step();
        checks++;
        if (p0_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_no_done got=%b exp=0", p0_done);
        end
        p0_req = 0;
        step();
        rst = 1'b0;
        step();
        p0_req = 1;
        step(); step();
        checks++;
        if ({p0_done, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("[TB] FAIL rstmid_fresh_read got=%b/%h exp=1/deadbeef", p0_done, p0_rdata);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_noop();
        p1_req = 1; p1_addr = 32'h30; p1_rstrb = 0; p1_wmask = 0; p1_wdata = 32'hFFFFFFFF;
        step();
        checks++;
        if ({mem_rstrb, mem_wmask, p1_done} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL noop_strobes got=%b/%b/%b exp=0/0000/0", mem_rstrb, mem_wmask, p1_done);
        end
        step();
        checks++;
        if ({p1_done, mem_rstrb, mem_wmask} !== {1'b1, 1'b0, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL noop_done got=%b/%b/%b exp=1/0/0000", p1_done, mem_rstrb, mem_wmask);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_stats();
        logic [15:0] e0, e1, ec;
        do_reset();
        p0_addr = 32'h10; p0_rstrb = 1; p1_addr = 32'h20; p1_rstrb = 1;
        for (int k = 0; k < 3; k++) begin
            p0_req = 1;
            step(); step();
            p0_req = 0;
            step();
        end
        for (int k = 0; k < 2; k++) begin
            p0_req = 1; p1_req = 1;
            for (int i = 0; i < 8; i++) begin
                step();
                if (p0_done) p0_req = 0;
                if (p1_done) p1_req = 0;
            end
        end
        idle_inputs();
        step();
`ifdef MEM_ARB_STATS_EN
        e0 = 16'd5; e1 = 16'd2; ec = 16'd2;
`else
        e0 = 16'd0; e1 = 16'd0; ec = 16'd0;
`endif
        checks++;
        if ({stat_p0_grants, stat_p1_grants, stat_conflicts} !== {e0, e1, ec}) begin
            failures++;
            $display("[TB] FAIL stats got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     stat_p0_grants, stat_p1_grants, stat_conflicts, e0, e1, ec);
        end
    endtask

    task automatic test_random();
        bit          busy [2];
        int          waitc [2];
        logic [31:0] t_addr [2];
        logic [31:0] t_wdata [2];
        logic        t_rstrb [2];
        logic [3:0]  t_wmask [2];
        logic        d;
        logic [31:0] rd;
        int          idx;
        do_reset();
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        for (int n = 0; n < 2; n++) begin
            busy[n] = 0; waitc[n] = 0; t_addr[n] = 0; t_wdata[n] = 0; t_rstrb[n] = 0; t_wmask[n] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            checks++;
            if (p0_done && p1_done) begin
                failures++;
                $display("[TB] FAIL rand_dual_done cyc=%0d got=11 exp=one-hot", cyc);
            end
            for (int n = 0; n < 2; n++) begin
                d  = (n == 0) ? p0_done : p1_done;
                rd = (n == 0) ? p0_rdata : p1_rdata;
                if (busy[n]) waitc[n]++;
                if (d) begin
                    checks++;
                    if (!busy[n]) begin
                        failures++;
                        $display("[TB] FAIL rand_spurious_done port=%0d cyc=%0d got=1 exp=0", n, cyc);
                    end else begin
                        idx = int'(t_addr[n][7:2]);
                        if (t_rstrb[n]) begin
                            checks++;
                            if (rd !== refm[idx]) begin
                                failures++;
                                $display("[TB] FAIL rand_rdata port=%0d addr=%h got=%h exp=%h", n, t_addr[n], rd, refm[idx]);
                            end
                        end
                        for (int b = 0; b < 4; b++) begin
                            if (t_wmask[n][b]) refm[idx][8*b +: 8] = t_wdata[n][8*b +: 8];
                        end
                        busy[n] = 0;
                    end
                end else if (busy[n] && waitc[n] >= 6) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rand_timeout port=%0d cyc=%0d waited=%0d exp<6", n, cyc, waitc[n]);
                    busy[n] = 0;
                end
                if (!busy[n] && ($urandom_range(0, 2) == 0)) begin
                    busy[n]    = 1;
                    waitc[n]   = 0;
                    t_addr[n]  = 32'($urandom_range(0, 255));
                    t_rstrb[n] = 1'($urandom_range(0, 1));
                    t_wmask[n] = 4'($urandom_range(0, 15));
                    t_wdata[n] = $urandom;
                end
            end
            p0_req = busy[0]; p0_addr = t_addr[0]; p0_rstrb = t_rstrb[0]; p0_wmask = t_wmask[0]; p0_wdata = t_wdata[0];
            p1_req = busy[1]; p1_addr = t_addr[1]; p1_rstrb = t_rstrb[1]; p1_wmask = t_wmask[1]; p1_wdata = t_wdata[1];
        end
        idle_inputs();
        step(); step(); step();
    endtask

    // Directed scenarios first, then the randomized run, then the summary
    initial begin
        pre_en = 1'b0; pre_idx = 0; pre_data = 0;
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_p0_read();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid();
        test_noop();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
